// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for a single FIFO: NUM_REQ valid/accept requesters,
// bursts capped at MAX_BURST beats, one IDLE arbitration cycle between bursts.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         gnt,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy
);

    localparam int unsigned OW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;

    logic [OW-1:0] pick;
    logic [OW-1:0] cand;
    logic [OW-1:0] owner_next;
    logic          beat;

    // Walk downward so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        pick = '0;
        cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = OW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req[cand]) begin
                pick = cand;
            end
        end
    end

    // Explicit wrap: NUM_REQ need not be a power of two.
    assign owner_next = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign beat       = req[owner_q] & ~fifo_full;
    assign owner      = owner_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        gnt          = '0;
        fifo_wr_en   = 1'b0;
        fifo_data_in = '0;
        busy         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    owner_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = StGrant;
                end
            end
            StGrant: begin
                busy         = 1'b1;
                fifo_data_in = req_data[owner_q*WIDTH +: WIDTH];
                if (beat) begin
                    gnt[owner_q] = 1'b1;
                    fifo_wr_en   = 1'b1;
                    if (req_last[owner_q] || beat_cnt_q == CW'(MAX_BURST - 1)) begin
                        state_d  = StIdle;
                        rr_ptr_d = owner_next;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end else if (!req[owner_q]) begin
                    state_d  = StIdle;
                    rr_ptr_d = owner_next;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule
